// File: rtl/pic_ack_controller_pkg.sv
// pic_pkg: shared types, constants and priority helpers for the PIC acknowledge controller
package pic_pkg;
    localparam int N_IRQ = 8;
    localparam logic [2:0] LP_RESET = 3'd7;
    localparam int VEC_BASE_W = 5;

    typedef logic [2:0] level_t;
    typedef enum logic [2:0] {IDLE, PEND, ACK1, WAIT2, VEC} state_t;

    function automatic logic [7:0] rot_r(logic [7:0] v, level_t n);
        logic [15:0] w;
        w = {v, v} >> n;
        return w[7:0];
    endfunction

    function automatic level_t first_set(logic [7:0] v);
        level_t r;
        r = '0;
        for (int i = 7; i >= 0; i--) if (v[i]) r = level_t'(i);
        return r;
    endfunction
endpackage

// File: rtl/pic_ack_controller_if.sv
// pic_ack_controller_if: request, EOI, configuration and vector bus of the acknowledge controller
interface pic_ack_controller_if;
    import pic_pkg::*;
    logic [7:0] IRR;
    logic [7:0] IMR;
    logic INTA_n;
    logic EOI;
    logic SEOI;
    level_t SEOI_LEVEL;
    logic AEOI;
    logic ROTATE;
    logic [VEC_BASE_W-1:0] VEC_BASE;
    logic INT;
    logic [7:0] chosen;
    logic [7:0] ISR;
    logic [7:0] DATA_OUT;
    logic DATA_OE;

    modport master (
        output IRR, IMR, INTA_n, EOI, SEOI, SEOI_LEVEL, AEOI, ROTATE, VEC_BASE,
        input INT, chosen, ISR, DATA_OUT, DATA_OE
    );
    modport slave (
        input IRR, IMR, INTA_n, EOI, SEOI, SEOI_LEVEL, AEOI, ROTATE, VEC_BASE,
        output INT, chosen, ISR, DATA_OUT, DATA_OE
    );
endinterface

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: rotating-priority pick of the request and of the top in-service level
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] req,
    input  logic [7:0] isr,
    input  level_t     lp,
    output level_t     cand,
    output logic       cand_ok,
    output level_t     isr_top,
    output logic       isr_any
);
    level_t base;
    level_t req_i;
    level_t isr_i;

    // rotate so index 0 is the highest priority, find first, rotate the index back
    always_comb begin
        base = lp + 3'd1;
        req_i = first_set(rot_r(req, base));
        isr_i = first_set(rot_r(isr, base));
        cand = req_i + base;
        isr_top = isr_i + base;
        isr_any = |isr;
        cand_ok = (|req) && (!isr_any || req_i < isr_i);
    end
endmodule

// File: rtl/pic_ack_controller.sv
// pic_ack_controller: priority arbitration, INTA handshake, ISR and vector generation
module pic_ack_controller #(
    parameter int N_IRQ = 8,
    parameter logic [2:0] LP_RESET = 3'd7
) (
    input logic CLK,
    input logic RST,
    pic_ack_controller_if.slave bus
);
    import pic_pkg::*;

    localparam logic [N_IRQ-1:0] ONE = 1;

    state_t state_q, state_d;
    level_t lp_q, lp_d, lvl_q, lvl_d, cand, isr_top;
    logic inta_prev_q, int_q, int_d, oe_q, oe_d;
    logic cand_ok, isr_any, fall, rise, first, auto_eoi;
    logic [N_IRQ-1:0] isr_q, isr_d, chosen_q, chosen_d, set_v, clr_v;
    logic [7:0] dout_q, dout_d;

    pic_priority_resolver u_res (
        .req     (bus.IRR & ~bus.IMR),
        .isr     (isr_q),
        .lp      (lp_q),
        .cand    (cand),
        .cand_ok (cand_ok),
        .isr_top (isr_top),
        .isr_any (isr_any)
    );

    assign fall = inta_prev_q & ~bus.INTA_n;
    assign rise = ~inta_prev_q & bus.INTA_n;
    assign bus.INT = int_q;
    assign bus.chosen = chosen_q;
    assign bus.ISR = isr_q;
    assign bus.DATA_OUT = dout_q;
    assign bus.DATA_OE = oe_q;

    // handshake state register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else state_q <= state_d;
    end

    // handshake sequencing; a falling edge in PEND wins over a withdrawn request (spurious ack)
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cand_ok ? PEND : IDLE;
            PEND:    state_d = fall ? ACK1 : (cand_ok ? PEND : IDLE);
            ACK1:    state_d = rise ? WAIT2 : ACK1;
            WAIT2:   state_d = fall ? VEC : WAIT2;
            VEC:     state_d = rise ? IDLE : VEC;
            default: state_d = IDLE;
        endcase
    end

    // ISR clears use the old ISR before the new level is set; auto-EOI rotation beats EOI rotation
    always_comb begin
        first = (state_q == PEND) && fall;
        auto_eoi = (state_q == VEC) && rise && bus.AEOI;
        set_v = (first && cand_ok) ? ONE << cand : '0;
        clr_v = ((bus.EOI && isr_any) ? ONE << isr_top : '0)
              | (bus.SEOI ? ONE << bus.SEOI_LEVEL : '0)
              | (auto_eoi ? ONE << lvl_q : '0);
        isr_d = (isr_q & ~clr_v) | set_v;
        chosen_d = set_v;
        lvl_d = first ? (cand_ok ? cand : 3'd7) : lvl_q;
        lp_d = (auto_eoi && bus.ROTATE) ? lvl_q
             : ((bus.EOI && isr_any && bus.ROTATE) ? isr_top : lp_q);
        int_d = state_d == PEND;
        oe_d = state_d == VEC;
        dout_d = oe_d ? {bus.VEC_BASE, lvl_d} : '0;
    end

    // datapath and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            lp_q <= LP_RESET;
            lvl_q <= '0;
            isr_q <= '0;
            chosen_q <= '0;
            int_q <= 1'b0;
            oe_q <= 1'b0;
            dout_q <= '0;
            inta_prev_q <= 1'b1;
        end else begin
            lp_q <= lp_d;
            lvl_q <= lvl_d;
            isr_q <= isr_d;
            chosen_q <= chosen_d;
            int_q <= int_d;
            oe_q <= oe_d;
            dout_q <= dout_d;
            inta_prev_q <= bus.INTA_n;
        end
    end
endmodule

// File: tb/tb_pic_ack_controller.sv
// tb_pic_ack_controller: directed and randomized checks against a behavioural PIC model
module tb_pic_ack_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    logic [7:0] m_isr, m_ch, m_dout;
    logic m_int, m_oe, m_prev;
    logic [2:0] m_lp, m_lvl;
    int m_ph;
    logic [7:0] ch, dv;

    pic_ack_controller_if bus();
    pic_ack_controller dut (.CLK(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    endtask

    // phases: 0 idle, 1 INT raised, 2 first INTA low, 3 between pulses, 4 vector driven
    always @(posedge clk) begin : model
        logic [7:0] req, nisr;
        logic [2:0] lv, c, h;
        logic fall, rise, serv, done, hv;
        if (rst) begin
            m_isr = 0; m_lp = 3'd7; m_ph = 0; m_lvl = 0; m_prev = 1;
            m_int = 0; m_ch = 0; m_dout = 0; m_oe = 0;
        end else begin
            fall = m_prev && !bus.INTA_n;
            rise = !m_prev && bus.INTA_n;
            req = bus.IRR & ~bus.IMR;
            serv = 0; done = 0; c = 3'd7; hv = 0; h = 0;
            for (int k = 1; k <= 8; k++) begin
                lv = m_lp + 3'(k);
                if (!done && m_isr[lv]) done = 1;
                if (!done && req[lv]) begin serv = 1; c = lv; done = 1; end
                if (!hv && m_isr[lv]) begin hv = 1; h = lv; end
            end
            nisr = m_isr;
            m_ch = 0;
            if (bus.EOI && hv) begin nisr[h] = 0; if (bus.ROTATE) m_lp = h; end
            if (bus.SEOI) nisr[bus.SEOI_LEVEL] = 0;
            case (m_ph)
                0: if (serv) m_ph = 1;
                1: if (fall) begin
                       m_lvl = serv ? c : 3'd7;
                       if (serv) begin nisr[c] = 1; m_ch[c] = 1; end
                       m_ph = 2;
                   end else if (!serv) m_ph = 0;
                2: if (rise) m_ph = 3;
                3: if (fall) m_ph = 4;
                default: if (rise) begin
                       m_ph = 0;
                       if (bus.AEOI) begin nisr[m_lvl] = 0; if (bus.ROTATE) m_lp = m_lvl; end
                   end
            endcase
            m_isr = nisr;
            m_int = m_ph == 1;
            m_oe = m_ph == 4;
            m_dout = m_oe ? {bus.VEC_BASE, m_lvl} : 8'h00;
            m_prev = bus.INTA_n;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("INT", {7'd0, bus.INT}, {7'd0, m_int});
            chk("chosen", bus.chosen, m_ch);
            chk("ISR", bus.ISR, m_isr);
            chk("DATA_OUT", bus.DATA_OUT, m_dout);
            chk("DATA_OE", {7'd0, bus.DATA_OE}, {7'd0, m_oe});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack(output logic [7:0] c_o, output logic [7:0] v_o);
        bus.INTA_n = 0; cyc(1); c_o = bus.chosen; cyc(1);
        bus.INTA_n = 1; cyc(2);
        bus.INTA_n = 0; cyc(1); v_o = bus.DATA_OUT; cyc(1);
        bus.INTA_n = 1; cyc(2);
    endtask

    task automatic eoi();
        bus.EOI = 1; cyc(1); bus.EOI = 0;
    endtask

    task automatic seoi(input logic [2:0] l);
        bus.SEOI = 1; bus.SEOI_LEVEL = l; cyc(1); bus.SEOI = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_int"}, {7'd0, bus.INT}, 8'h00);
        chk({tag, "_isr"}, bus.ISR, 8'h00);
        chk({tag, "_chosen"}, bus.chosen, 8'h00);
        chk({tag, "_oe"}, {7'd0, bus.DATA_OE}, 8'h00);
        chk({tag, "_dout"}, bus.DATA_OUT, 8'h00);
    endtask

    initial begin
        bus.IRR = 0; bus.IMR = 0; bus.INTA_n = 1; bus.EOI = 0; bus.SEOI = 0;
        bus.SEOI_LEVEL = 0; bus.AEOI = 0; bus.ROTATE = 0; bus.VEC_BASE = 5'h08;
        cyc(2); rst = 0; chk_en = 1;
        chk_zero("reset");
        bus.IRR = 8'h08; cyc(1);
        chk("single_int_rise", {7'd0, bus.INT}, 8'h01);
        ack(ch, dv);
        chk("single_chosen", ch, 8'h08);
        chk("single_vector", dv, 8'h43);
        chk("single_isr", bus.ISR, 8'h08);
        bus.IRR = 0; seoi(3'd3);
        chk("seoi_isr", bus.ISR, 8'h00);
        bus.IRR = 8'h04; cyc(2); ack(ch, dv); bus.IRR = 0;
        chk("nest_first", ch, 8'h04);
        bus.IRR = 8'h20; cyc(3);
        chk("nest_blocked_int", {7'd0, bus.INT}, 8'h00);
        bus.IRR = 8'h02; cyc(2);
        chk("nest_higher_int", {7'd0, bus.INT}, 8'h01);
        ack(ch, dv); bus.IRR = 0;
        chk("nest_chosen", ch, 8'h02);
        chk("nest_isr", bus.ISR, 8'h06);
        eoi(); chk("eoi_top_isr", bus.ISR, 8'h04);
        eoi(); chk("eoi_next_isr", bus.ISR, 8'h00);
        bus.IRR = 8'h81; bus.IMR = 8'h01; cyc(2); ack(ch, dv);
        bus.IRR = 0; bus.IMR = 0;
        chk("mask_vector", dv, 8'h47);
        chk("mask_chosen", ch, 8'h80);
        eoi(); chk("mask_eoi_isr", bus.ISR, 8'h00);
        bus.ROTATE = 1; bus.IRR = 8'h08; cyc(2); ack(ch, dv); bus.IRR = 0;
        chk("rot_first", ch, 8'h08);
        eoi(); chk("rot_eoi_isr", bus.ISR, 8'h00);
        chk("model_lp_rot", {5'd0, m_lp}, 8'h03);
        bus.IRR = 8'h11; cyc(2); ack(ch, dv); bus.IRR = 0;
        chk("rot_pick_ir4", ch, 8'h10);
        seoi(3'd4); bus.ROTATE = 0;
        bus.AEOI = 1; bus.IRR = 8'h02; cyc(2); ack(ch, dv);
        chk("aeoi_chosen", ch, 8'h02);
        chk("aeoi_isr", bus.ISR, 8'h00);
        bus.IRR = 0; bus.AEOI = 0; cyc(2);
        bus.IRR = 8'h01; cyc(2); bus.IRR = 0; ack(ch, dv);
        chk("spur_chosen", ch, 8'h00);
        chk("spur_vector", dv, 8'h47);
        chk("spur_isr", bus.ISR, 8'h00);
        bus.IRR = 8'h04; cyc(2);
        bus.INTA_n = 0; cyc(2); bus.INTA_n = 1; cyc(2);
        chk("wait2_isr", bus.ISR, 8'h04);
        rst = 1; cyc(1);
        chk_zero("rst_wait2");
        chk("model_lp_rst", {5'd0, m_lp}, 8'h07);
        rst = 0; bus.IRR = 8'h81; cyc(2); ack(ch, dv); bus.IRR = 0;
        chk("lp_reset_pick", ch, 8'h01);
        seoi(3'd0);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0) bus.IRR = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 15) == 0) bus.IMR = 8'($urandom) & 8'($urandom) & 8'($urandom);
            bus.EOI = ($urandom_range(0, 9) == 0);
            bus.SEOI = ($urandom_range(0, 11) == 0);
            bus.SEOI_LEVEL = 3'($urandom);
            if ($urandom_range(0, 2) == 0) bus.INTA_n = ~bus.INTA_n;
            if ($urandom_range(0, 63) == 0) bus.AEOI = 1'($urandom);
            if ($urandom_range(0, 63) == 0) bus.ROTATE = 1'($urandom);
            if ($urandom_range(0, 99) == 0) bus.VEC_BASE = 5'($urandom);
        end
        rst = 0; bus.EOI = 0; bus.SEOI = 0; bus.INTA_n = 1;
        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
